lector_boton_antirrebote: RTL and testbench

- Input-side counterpart of the LED driver: it reads a raw, bouncing push-button from the board and converts it into clean, synchronous signals.
- Outputs are a debounced level, one-cycle press and release pulses, and a toggle register that can drive an LED directly.
- The block sits between the board button pin and the user logic, in the same clock domain as the clock divider.

---
 rtl/lector_boton_antirrebote.sv | 94 +++++++++
 tb/tb_lector_boton_antirrebote.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lector_boton_antirrebote.sv
// Push-button reader: two-flop synchronizer, four-state debounce FSM, and registered
// level, press/release pulses and an LED toggle. Every output comes straight from a flop.
module lector_boton_antirrebote #(
  parameter int CICLOS_ESTABLES = 500000,
  parameter int ANCHO_CONTADOR  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic nivel,
  output logic pulso_presion,
  output logic pulso_liberacion,
  output logic conmutado
);

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    VALIDANDO_ALTO,
    ESTABLE_ALTO,
    VALIDANDO_BAJO
  } estado_t;

  localparam logic [ANCHO_CONTADOR-1:0] ULTIMO = ANCHO_CONTADOR'(CICLOS_ESTABLES - 1);

  logic                      s1, s2;
  estado_t                   estado, estado_sig;
  logic [ANCHO_CONTADOR-1:0] contador, contador_sig;
  logic                      nivel_sig, presion_sig, liberacion_sig, conmutado_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1               <= 1'b0;
      s2               <= 1'b0;
      estado           <= ESTABLE_BAJO;
      contador         <= '0;
      nivel            <= 1'b0;
      pulso_presion    <= 1'b0;
      pulso_liberacion <= 1'b0;
      conmutado        <= 1'b0;
    end else begin
      s1               <= boton;
      s2               <= s1;
      estado           <= estado_sig;
      contador         <= contador_sig;
      nivel            <= nivel_sig;
      pulso_presion    <= presion_sig;
      pulso_liberacion <= liberacion_sig;
      conmutado        <= conmutado_sig;
    end
  end

  // Counter is cleared on every transition and in both stable states, so bounces never accumulate.
  always_comb begin
    estado_sig     = estado;
    contador_sig   = '0;
    nivel_sig      = nivel;
    presion_sig    = 1'b0;
    liberacion_sig = 1'b0;
    conmutado_sig  = conmutado;
    case (estado)
      ESTABLE_BAJO: begin
        if (s2) estado_sig = VALIDANDO_ALTO;
      end
      VALIDANDO_ALTO: begin
        if (!s2) begin
          estado_sig = ESTABLE_BAJO;
        end else if (contador == ULTIMO) begin
          estado_sig    = ESTABLE_ALTO;
          nivel_sig     = 1'b1;
          presion_sig   = 1'b1;
          conmutado_sig = ~conmutado;
        end else begin
          contador_sig = contador + 1'b1;
        end
      end
      ESTABLE_ALTO: begin
        if (!s2) estado_sig = VALIDANDO_BAJO;
      end
      VALIDANDO_BAJO: begin
        if (s2) begin
          estado_sig = ESTABLE_ALTO;
        end else if (contador == ULTIMO) begin
          estado_sig     = ESTABLE_BAJO;
          nivel_sig      = 1'b0;
          liberacion_sig = 1'b1;
        end else begin
          contador_sig = contador + 1'b1;
        end
      end
      default: estado_sig = ESTABLE_BAJO;
    endcase
  end

endmodule

// File: tb/tb_lector_boton_antirrebote.sv
// Bench for lector_boton_antirrebote with CICLOS_ESTABLES=4: a run-length model feeds a
// per-edge scoreboard queue, plus directed latency and pulse-count checks.
module tb_lector_boton_antirrebote;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst, boton;
  logic nivel, pulso_presion, pulso_liberacion, conmutado;

  always #5 clk = ~clk;

  lector_boton_antirrebote #(
    .CICLOS_ESTABLES(C),
    .ANCHO_CONTADOR (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .boton           (boton),
    .nivel           (nivel),
    .pulso_presion   (pulso_presion),
    .pulso_liberacion(pulso_liberacion),
    .conmutado       (conmutado)
  );

  typedef struct packed {
    logic nivel;
    logic presion;
    logic liberacion;
    logic conmutado;
  } salida_t;

  salida_t cola[$];
  salida_t esp_q;

  int errores = 0;
  int checks  = 0;

  logic m_s1 = 1'b0, m_s2 = 1'b0, m_nivel = 1'b0, m_conm = 1'b0;
  int   m_racha = 0;

  int   ciclo = 0;
  int   ultimo_flanco = 0;
  int   n_presion = 0, n_liberacion = 0;
  int   flanco_subida = -1, flanco_bajada = -1;
  logic nivel_prev = 1'b0;
  logic conm_seq[3];

  task automatic comprobar(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, esp, ciclo);
    end
  endtask

  // Reference: nivel flips once the synchronized input has disagreed with it for C+1 consecutive edges.
  task automatic aplicar(input logic b, input logic r);
    salida_t e;
    @(negedge clk);
    boton = b;
    rst   = r;
    ultimo_flanco = ciclo + 1;
    e = '0;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_nivel = 1'b0; m_conm = 1'b0; m_racha = 0;
    end else begin
      if (m_s2 != m_nivel) begin
        m_racha++;
        if (m_racha == C + 1) begin
          m_nivel = ~m_nivel;
          m_racha = 0;
          if (m_nivel) begin
            e.presion = 1'b1;
            m_conm    = ~m_conm;
          end else begin
            e.liberacion = 1'b1;
          end
        end
      end else begin
        m_racha = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    e.nivel     = m_nivel;
    e.conmutado = m_conm;
    cola.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    ciclo++;
    if (cola.size() > 0) begin
      esp_q = cola.pop_front();
      comprobar("nivel", int'(nivel), int'(esp_q.nivel));
      comprobar("pulso_presion", int'(pulso_presion), int'(esp_q.presion));
      comprobar("pulso_liberacion", int'(pulso_liberacion), int'(esp_q.liberacion));
      comprobar("conmutado", int'(conmutado), int'(esp_q.conmutado));
      comprobar("pulsos_exclusivos", int'(pulso_presion & pulso_liberacion), 0);
    end
    if (pulso_presion) begin
      if (n_presion < 3) conm_seq[n_presion] = conmutado;
      n_presion++;
    end
    if (pulso_liberacion) n_liberacion++;
    if (nivel && !nivel_prev) flanco_subida = ciclo;
    if (!nivel && nivel_prev) flanco_bajada = ciclo;
    nivel_prev = nivel;
  end

  task automatic limpiar_estadisticas();
    n_presion     = 0;
    n_liberacion  = 0;
    flanco_subida = -1;
    flanco_bajada = -1;
  endtask

  task automatic reiniciar();
    aplicar(1'b0, 1'b1);
    aplicar(1'b0, 1'b1);
    @(posedge clk);
    #2;
    limpiar_estadisticas();
  endtask

  logic patron[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int   k, r_flanco, presion_antes;

  initial begin
    rst   = 1'b1;
    boton = 1'b0;

    // Button held through reset
    repeat (3) aplicar(1'b1, 1'b1);
    @(posedge clk);
    #2;
    comprobar("t1_rst_nivel", int'(nivel), 0);
    comprobar("t1_rst_conmutado", int'(conmutado), 0);
    limpiar_estadisticas();
    aplicar(1'b1, 1'b0);
    k = ultimo_flanco;
    repeat (9) aplicar(1'b1, 1'b0);
    comprobar("t1_latencia", flanco_subida - k, 6);
    comprobar("t1_n_presion", n_presion, 1);
    comprobar("t1_conmutado", int'(conmutado), 1);

    // Clean press and release
    reiniciar();
    aplicar(1'b1, 1'b0);
    k = ultimo_flanco;
    repeat (19) aplicar(1'b1, 1'b0);
    comprobar("t2_latencia_presion", flanco_subida - k, 6);
    comprobar("t2_n_presion", n_presion, 1);
    comprobar("t2_conmutado_presion", int'(conmutado), 1);
    aplicar(1'b0, 1'b0);
    k = ultimo_flanco;
    repeat (19) aplicar(1'b0, 1'b0);
    comprobar("t2_latencia_liberacion", flanco_bajada - k, 6);
    comprobar("t2_n_liberacion", n_liberacion, 1);
    comprobar("t2_conmutado_liberacion", int'(conmutado), 1);

    // Bounce before settling
    reiniciar();
    for (int i = 0; i < 11; i++) begin
      aplicar(patron[i], 1'b0);
      if (i == 5) k = ultimo_flanco;
    end
    repeat (6) aplicar(1'b1, 1'b0);
    comprobar("t3_latencia", flanco_subida - k, 6);
    comprobar("t3_n_presion", n_presion, 1);

    // Short glitches rejected
    reiniciar();
    repeat (5) begin
      repeat (3) aplicar(1'b1, 1'b0);
      repeat (10) aplicar(1'b0, 1'b0);
    end
    comprobar("t4_n_presion", n_presion, 0);
    comprobar("t4_n_liberacion", n_liberacion, 0);
    comprobar("t4_subida", flanco_subida, -1);
    comprobar("t4_conmutado", int'(conmutado), 0);

    // Toggle sequence over three presses
    reiniciar();
    repeat (3) begin
      repeat (10) aplicar(1'b1, 1'b0);
      repeat (10) aplicar(1'b0, 1'b0);
    end
    comprobar("t5_n_presion", n_presion, 3);
    comprobar("t5_n_liberacion", n_liberacion, 3);
    comprobar("t5_conm_0", int'(conm_seq[0]), 1);
    comprobar("t5_conm_1", int'(conm_seq[1]), 0);
    comprobar("t5_conm_2", int'(conm_seq[2]), 1);

    // Reset while contador=2 in VALIDANDO_ALTO
    reiniciar();
    repeat (5) aplicar(1'b1, 1'b0);
    aplicar(1'b1, 1'b1);
    presion_antes = n_presion;
    aplicar(1'b1, 1'b0);
    r_flanco = ultimo_flanco;
    repeat (9) aplicar(1'b1, 1'b0);
    comprobar("t6_sin_pulso_previo", presion_antes, 0);
    comprobar("t6_latencia", flanco_subida - r_flanco, 6);
    comprobar("t6_n_presion", n_presion, 1);
    comprobar("t6_conmutado", int'(conmutado), 1);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
